// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_pkg                                                        |
// | Brief    : Shared types and constants for the inter-stage pipeline regs.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 16;

  localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_BUBBLE = '0;

  // ID/EX control-field layout within the control payload
  localparam int IDEX_BRANCH_BIT   = 0;
  localparam int IDEX_MEMREAD_BIT  = 1;
  localparam int IDEX_MEMWRITE_BIT = 2;
  localparam int IDEX_REGWRITE_BIT = 3;
  localparam int IDEX_MEMTOREG_BIT = 4;
  localparam int IDEX_ALUSRC_BIT   = 5;
  localparam int IDEX_ALUOP_LSB    = 6;
  localparam int IDEX_ALUOP_W      = 2;

  function automatic logic is_bubble(input logic [PIPE_CTRL_W-1:0] ctrl);
    return ctrl == PIPE_CTRL_BUBBLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_ctr16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sat_ctr16                                                       |
// | Brief    : 16-bit saturating event counter, sync active-low clear.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sat_ctr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= 16'h0000;
    end else if (en && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'h0001;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_stage_reg                                                  |
// | Brief    : Valid/ready pipeline register with 2-entry skid and flush.      |
// |            Define PIPE_STAGE_PERF_EN to add stall/flush counters.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = PIPE_DATA_W,
  parameter int                CTRL_W      = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`else
  output logic [CTRL_W-1:0] out_ctrl
`endif
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic w_push;
  logic w_pop;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_clear_main;

  // Handshake decoded from registered state only: no out_ready -> in_ready path
  assign in_ready  = (r_state != SKID);
  assign out_valid = (r_state != EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clear_main     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_nxt    = FULL;
          w_load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (w_push && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_push) begin
          w_state_nxt = SKID;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt  = EMPTY;
          w_clear_main = 1'b1;
        end
      end
      SKID: begin
        if (w_pop) begin
          w_state_nxt      = FULL;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = EMPTY;
        w_clear_main = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= CTRL_BUBBLE;
      r_skid_data <= '0;
      r_skid_ctrl <= CTRL_BUBBLE;
    end else if (flush) begin
      // Main data is left as-is; only the control is forced to a bubble
      r_state     <= EMPTY;
      r_main_ctrl <= CTRL_BUBBLE;
      r_skid_ctrl <= CTRL_BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end else if (w_clear_main) begin
        r_main_ctrl <= CTRL_BUBBLE;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  assign out_data = r_main_data;
  assign out_ctrl = r_main_ctrl;

`ifdef PIPE_STAGE_PERF_EN
  sat_ctr16 u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_ctr16 u_flush_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (flush),
    .count (flush_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_stage_reg                                               |
// | Brief    : Directed + random scoreboard bench for pipe_stage_reg.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  entry_t sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPE_STAGE_PERF_EN
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`else
    .out_ctrl  (out_ctrl)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge: drive, check registered outputs against the
  // scoreboard, advance the model, then move to the next falling edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl);
    bit do_push;
    bit do_pop;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("out_valid", {127'b0, out_valid}, {127'b0, (sb.size() > 0)});
    chk("in_ready", {127'b0, in_ready}, {127'b0, (sb.size() < 2)});
    if (sb.size() > 0) begin
      chk("out_data", out_data, sb[0].d);
      chk("out_ctrl", {112'b0, out_ctrl}, {112'b0, sb[0].c});
    end else begin
      chk("out_ctrl_bubble", {112'b0, out_ctrl}, '0);
    end
    if (fl) begin
      sb.delete();
    end else begin
      do_pop  = (sb.size() > 0) && ordy;
      do_push = v && (sb.size() < 2);
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back('{d: d, c: c});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h99;
    in_ctrl   = 16'h0003;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {127'b0, out_valid}, '0);
    chk("rst_out_ctrl", {112'b0, out_ctrl}, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'h1);
    rst = 1'b1;
    sb.delete();

    // First push after reset
    step(1'b1, 128'hA5, 16'h0011, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

    // Streaming
    step(1'b1, 128'h1, 16'h0101, 1'b1, 1'b0);
    step(1'b1, 128'h2, 16'h0202, 1'b1, 1'b0);
    step(1'b1, 128'h3, 16'h0303, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

    // Back-pressure into skid, refused push, then drain in order
    step(1'b1, 128'h10, 16'h1010, 1'b0, 1'b0);
    step(1'b1, 128'h11, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 128'h55, 16'h5555, 1'b0, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

    // Flush while in SKID with a same-cycle push
    step(1'b1, 128'h30, 16'h3030, 1'b0, 1'b0);
    step(1'b1, 128'h31, 16'h3131, 1'b0, 1'b0);
    step(1'b1, 128'h22, 16'h2222, 1'b1, 1'b1);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

    // Drain to bubble
    step(1'b1, 128'h40, 16'h00FF, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

    // Random mix of pushes, stalls and rare flushes
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
           16'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 128'h0, 16'h0, 1'b1, 1'b1);
    chk("flush_cnt", {112'b0, flush_cnt}, 128'd3);
    chk("stall_cnt_zero", {112'b0, stall_cnt}, '0);
    step(1'b1, 128'h77, 16'h0007, 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("stall_cnt_sat", {112'b0, stall_cnt}, 128'hFFFF);
    chk("hold_data", out_data, 128'h77);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    chk("stall_cnt_rst", {112'b0, stall_cnt}, '0);
    chk("flush_cnt_rst", {112'b0, flush_cnt}, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage core; replaces per-stage hard-wired registers (ID/EX first, then EX/MEM and MEM/WB).
- Carries a data payload and a control payload with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and flush-to-bubble.
- Latency 1 cycle; sustained throughput 1 transfer/cycle.

Parameters:
- DATA_W, 128, payload width (PC, imm, rs1/rs2 values, register indices, funct fields packed by caller).
- CTRL_W, 16, control-bit width (Branch, MemRead, MemWrite, RegWrite, ALUOp, ...); forced to CTRL_BUBBLE on flush/empty.
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented when no valid instruction is held.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  kill all held and incoming entries this cycle.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept; equals (state != SKID), decoded from registered state only.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  stage holds an entry.
- out_ready  in  1  downstream accepts (deasserted = stall).
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control; CTRL_BUBBLE whenever out_valid=0.

Behaviour:
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (drives outputs), skid register (holds one extra entry).
- States: EMPTY (none held), FULL (main only), SKID (main + skid).
- EMPTY: push -> FULL, main <= input. No push -> stay EMPTY.
- FULL: push & pop -> FULL, main <= input. push & !pop -> SKID, skid <= input. !push & pop -> EMPTY. Neither -> hold.
- SKID: in_ready=0. pop -> FULL, main <= skid. No pop -> hold both.
- On entering EMPTY, main ctrl <= CTRL_BUBBLE; data holds its last value (don't-care).
- out_data/out_ctrl come directly from the main register; no combinational input-to-output path.
- in_ready depends only on state (no combinational out_ready -> in_ready path).
- flush (priority below reset, above all else): state <= EMPTY; main ctrl <= CTRL_BUBBLE; skid dropped; any same-cycle push discarded. out_ready is ignored that cycle.
- Reset (rst=0 at edge): state EMPTY; out_valid=0; out_data=0; out_ctrl=CTRL_BUBBLE; skid cleared. Same as flush, and wins over it. A reset in SKID discards both entries.
- in_valid with in_ready=0: no state change; upstream must hold its data (not checked here).
- Payloads are stored unmodified; no arithmetic on them.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and their logic are absent. Core behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg: state enum {EMPTY, FULL, SKID} (2-bit), default DATA_W/CTRL_W constants, per-stage control-field bit-offset localparams (ID/EX layout), CTRL_BUBBLE default.
- Sub-module sat_ctr16 (16-bit saturating counter with enable and sync active-low clear), instantiated twice only under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1. After release, first push of data=0xA5 appears with out_valid=1 one cycle later.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> outputs 0x1,0x2,0x3 on the next 3 cycles, in_ready stays 1.
- Back-pressure: out_ready=0, push 0x10,0x11 -> state SKID, in_ready=0, out_data=0x10 held. Raise out_ready -> 0x10 then 0x11 delivered in order, none lost or duplicated.
- Flush in SKID, with in_valid=1 data=0x22 the same cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1. 0x22 never appears at the output.
- Drain: FULL with ctrl=16'h00FF, pop with no push -> out_valid=0 and out_ctrl=0 next cycle.
- PIPE_STAGE_PERF_EN: 70000 stall cycles -> stall_cnt=16'hFFFF. 3 flush pulses -> flush_cnt=3. Reset -> both 0.
